// File: rtl/seq_pkg.sv
// Shared types and helpers for the multi-slave sequencer.
package seq_pkg;

  // FSM state encoding; the numeric values are visible on the state output.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    ADVANCE = 2'd3
  } state_e;

  localparam logic MODE_SEQ = 1'b0;
  localparam logic MODE_PAR = 1'b1;

  // Channel selection result: valid plus 4-bit channel index (up to 16 channels).
  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } chan_sel_t;

  // Lowest set bit of a 16-bit channel mask.
  function automatic chan_sel_t lowest_chan(input logic [15:0] mask);
    chan_sel_t sel;
    sel = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) begin
        sel.valid = 1'b1;
        sel.idx   = 4'(i);
      end
    end
    return sel;
  endfunction

  // Lowest set bit strictly above cur.
  function automatic chan_sel_t next_chan(input logic [15:0] mask, input logic [3:0] cur);
    logic [15:0] above;
    // (2 << cur) - 1 covers bits 0..cur; wraps to all-ones-masked-out when cur == 15.
    above = mask & ~((16'd2 << cur) - 16'd1);
    return lowest_chan(above);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Per-launch wait counter with a terminal-count flag.
module wait_timer #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;

  // Counter: cleared on launch, advances once per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count   = count_q;
  assign expired = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multi_slave_sequencer.sv
// Launches enabled slave FSMs sequentially or in parallel and records per-channel timeouts.
module multi_slave_sequencer import seq_pkg::*; #(
  parameter int unsigned N_SLAVES       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned CNT_W          = 32,
  parameter bit          ABORT_ON_ERR   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [N_SLAVES-1:0] chan_en,
  output logic [N_SLAVES-1:0] slv_start,
  input  logic [N_SLAVES-1:0] slv_busy,
  input  logic [N_SLAVES-1:0] slv_done,
  output logic [1:0]          state,
  output logic [3:0]          cur_chan,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [N_SLAVES-1:0] err_mask
);

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [N_SLAVES-1:0] en_q, en_d;
  logic [N_SLAVES-1:0] pend_q, pend_d;
  logic [N_SLAVES-1:0] err_mask_q, err_mask_d;
  logic                error_q, error_d;
  logic [3:0]          cur_q, cur_d;

  logic [CNT_W-1:0]    count;
  logic                expired, tmr_clr, tmr_en;
  logic [N_SLAVES-1:0] cmpl, cur_sel, pend_left;
  chan_sel_t           first_sel, next_sel;

  wait_timer #(
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .count  (count),
    .expired(expired)
  );

  // Completion is masked on the first WAIT cycle so a stale idle done is not taken as finished.
  assign cmpl      = ~slv_busy & slv_done & {N_SLAVES{count != '0}};
  assign cur_sel   = N_SLAVES'(1) << cur_q;
  assign pend_left = pend_q & ~cmpl;
  assign first_sel = lowest_chan(16'(chan_en));
  assign next_sel  = next_chan(16'(en_q), cur_q);

  // State and run-context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= MODE_SEQ;
      en_q       <= '0;
      pend_q     <= '0;
      err_mask_q <= '0;
      error_q    <= 1'b0;
      cur_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      en_q       <= en_d;
      pend_q     <= pend_d;
      err_mask_q <= err_mask_d;
      error_q    <= error_d;
      cur_q      <= cur_d;
    end
  end

  // Next-state, launch pulses and timer control.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    en_d       = en_q;
    pend_d     = pend_q;
    err_mask_d = err_mask_q;
    error_d    = error_q;
    cur_d      = cur_q;
    slv_start  = '0;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && first_sel.valid) begin
          state_d    = LAUNCH;
          mode_d     = mode;
          en_d       = chan_en;
          err_mask_d = '0;
          error_d    = 1'b0;
          cur_d      = (mode == MODE_SEQ) ? first_sel.idx : 4'd0;
        end
      end
      LAUNCH: begin
        tmr_clr = 1'b1;
        state_d = WAIT;
        if (mode_q == MODE_SEQ) begin
          slv_start = cur_sel;
        end else begin
          slv_start = en_q;
          pend_d    = en_q;
        end
      end
      WAIT: begin
        tmr_en = 1'b1;
        if (mode_q == MODE_SEQ) begin
          if ((cmpl & cur_sel) != '0) begin
            state_d = ADVANCE;
          end else if (expired) begin
            err_mask_d = err_mask_q | cur_sel;
            error_d    = 1'b1;
            if (ABORT_ON_ERR) begin
              state_d = IDLE;
              cur_d   = '0;
            end else begin
              state_d = ADVANCE;
            end
          end
        end else begin
          pend_d = pend_left;
          if (pend_left == '0) begin
            state_d = IDLE;
          end else if (expired) begin
            err_mask_d = err_mask_q | pend_left;
            error_d    = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      ADVANCE: begin
        if (next_sel.valid) begin
          cur_d   = next_sel.idx;
          state_d = LAUNCH;
        end else begin
          cur_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cur_d   = '0;
      end
    endcase
  end

  assign state    = state_q;
  assign cur_chan = cur_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == IDLE);
  assign error    = error_q;
  assign err_mask = err_mask_q;

endmodule
